// File: rtl/handshake_req_tx.sv
// handshake_req_tx
// Source side of a four-phase req/ack handshake that carries single-cycle
// events into another clock domain. Incoming pulses are queued in a
// saturating counter and served one at a time; each one is a full
// req-up / ack-up / req-down / ack-down cycle.
//
// Parameters:
//   SYNC_STAGES : flops in the ack_async synchronizer (>= 2)
//   CNT_W       : width of the pending-event counter
// Ports:
//   sys_clk     : clock, rising edge
//   sys_rst     : asynchronous active-high reset
//   pulse_in    : one-cycle event request
//   ack_async   : acknowledge level from the destination domain
//   clr_ovf     : synchronous clear of ovf_sticky
//   req         : registered request level to the destination
//   busy        : handshake in progress or events pending
//   done_pulse  : one-cycle pulse when a four-phase cycle completes
//   pending     : queued events not yet started
//   ovf_pulse   : one-cycle pulse when an event is dropped
//   ovf_sticky  : latched overflow flag
module handshake_req_tx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             pulse_in,
  input  logic             ack_async,
  input  logic             clr_ovf,
  output logic             req,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] pending,
  output logic             ovf_pulse,
  output logic             ovf_sticky
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   req_d, done_d, ovf_d, sticky_d;
  logic [CNT_W-1:0]       pending_d;
  logic                   enqueue;

  assign ack_s = ack_sync[SYNC_STAGES-1];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_async};
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      req        <= 1'b0;
      done_pulse <= 1'b0;
      pending    <= '0;
      ovf_pulse  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      state      <= state_d;
      req        <= req_d;
      done_pulse <= done_d;
      pending    <= pending_d;
      ovf_pulse  <= ovf_d;
      ovf_sticky <= sticky_d;
    end
  end

  always_comb begin
    state_d   = state;
    req_d     = req;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    pending_d = pending;
    enqueue   = 1'b0;
    // Clear first so a same-cycle overflow below wins.
    sticky_d  = ovf_sticky & ~clr_ovf;

    case (state)
      IDLE: begin
        // ack_s high here means the destination has not released yet;
        // hold off and queue instead of starting a new request.
        if (!ack_s && (pulse_in || (pending != '0))) begin
          state_d = REQ;
          req_d   = 1'b1;
          if (pending != '0) begin
            pending_d = pending - CNT_W'(1) + CNT_W'(pulse_in);
          end
        end else begin
          enqueue = pulse_in;
        end
      end
      REQ: begin
        enqueue = pulse_in;
        if (ack_s) begin
          state_d = REL;
          req_d   = 1'b0;
        end
      end
      REL: begin
        enqueue = pulse_in;
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (enqueue) begin
      if (pending == '1) begin
        ovf_d    = 1'b1;
        sticky_d = 1'b1;
      end else begin
        pending_d = pending + CNT_W'(1);
      end
    end
  end

  always_comb begin
    busy = (state != IDLE) || (pending != '0);
  end

endmodule

// File: tb/tb_handshake_req_tx.sv
// Self-checking bench for handshake_req_tx: directed scenarios plus
// randomized pulse traffic against an event-level reference model, with a
// destination model that returns req as ack after a configurable delay.
module tb_handshake_req_tx;

  localparam int unsigned SS = 2;
  localparam int unsigned CW = 2;
  localparam int MAXP = (1 << CW) - 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          pulse_in = 1'b0;
  logic          ack_async = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          req, busy, done_pulse, ovf_pulse, ovf_sticky;
  logic [CW-1:0] pending;

  int checks = 0;
  int passes = 0;

  // destination model
  int ack_mode = 0;       // 0: ack = req delayed by dly edges, 1: forced
  bit ack_force = 1'b0;
  int dly = 0;
  bit req_hist[$];

  // reference model: handshake step 0 = waiting, 1 = request out,
  // 2 = waiting for release; plus queued-event count and flags
  int m_step, m_pend;
  bit m_req, m_done, m_ovf, m_sticky;
  bit samp[$];

  always #5 sys_clk = ~sys_clk;

  handshake_req_tx #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .pulse_in  (pulse_in),
    .ack_async (ack_async),
    .clr_ovf   (clr_ovf),
    .req       (req),
    .busy      (busy),
    .done_pulse(done_pulse),
    .pending   (pending),
    .ovf_pulse (ovf_pulse),
    .ovf_sticky(ovf_sticky)
  );

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic update_ack();
    req_hist.push_front(req);
    if (req_hist.size() > 64) void'(req_hist.pop_back());
    if (ack_mode == 1) ack_async = ack_force;
    else ack_async = (dly < req_hist.size()) ? req_hist[dly] : 1'b0;
  endtask

  // One clock edge: apply the model to the inputs the DUT samples at this
  // edge, then compare every output just after the edge.
  task automatic tick();
    bit p, c, a, as_seen, q;
    p = pulse_in; c = clr_ovf; a = ack_async;
    @(posedge sys_clk);
    // the FSM reacts to the ack level that was sampled SS edges earlier
    as_seen = (samp.size() >= SS) ? samp[samp.size() - SS] : 1'b0;
    samp.push_back(a);
    if (samp.size() > SS) void'(samp.pop_front());
    m_done = 0; m_ovf = 0; q = 0;
    if (m_step == 0) begin
      if (!as_seen && (p || m_pend > 0)) begin
        m_step = 1;
        if (m_pend > 0) m_pend = m_pend - 1 + int'(p);
      end else q = p;
    end else if (m_step == 1) begin
      q = p;
      if (as_seen) m_step = 2;
    end else begin
      q = p;
      if (!as_seen) begin m_step = 0; m_done = 1; end
    end
    m_req = (m_step == 1);
    if (c) m_sticky = 0;
    if (q) begin
      if (m_pend == MAXP) begin m_ovf = 1; m_sticky = 1; end
      else m_pend++;
    end
    #1;
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    update_ack();
    check("m_req", req, m_req);
    check("m_done", done_pulse, m_done);
    check("m_pending", pending, m_pend);
    check("m_ovf", ovf_pulse, m_ovf);
    check("m_sticky", ovf_sticky, m_sticky);
    check("m_busy", busy, int'(m_step != 0 || m_pend != 0));
  endtask

  task automatic do_reset(input int mode, input bit fv, input int d);
    #3;
    sys_rst = 1'b1;
    #1;
    check("rst_req", req, 0);
    check("rst_done", done_pulse, 0);
    check("rst_pending", pending, 0);
    check("rst_ovf", ovf_pulse, 0);
    check("rst_sticky", ovf_sticky, 0);
    check("rst_busy", busy, 0);
    pulse_in = 1'b0; clr_ovf = 1'b0;
    ack_mode = mode; ack_force = fv; dly = d;
    req_hist.delete(); samp.delete();
    m_step = 0; m_pend = 0; m_req = 0; m_done = 0; m_ovf = 0; m_sticky = 0;
    @(posedge sys_clk); @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    update_ack();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_req[7]  = '{1, 1, 1, 0, 0, 0, 0};
    bit exp_done[7] = '{0, 0, 0, 0, 0, 0, 1};
    int rises[$];
    int dones, run, prev, seen;

    // single event, loopback
    do_reset(0, 0, 0);
    pulse_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("lb_req", req, exp_req[i]);
      check("lb_done", done_pulse, exp_done[i]);
    end
    check("lb_pending", pending, 0);
    check("lb_busy", busy, 0);

    // burst of three pulses, loopback
    do_reset(0, 0, 0);
    rises.delete(); dones = 0;
    for (int i = 0; i < 30; i++) begin
      pulse_in = (i < 3);
      prev = req;
      tick();
      if (!prev && req) begin
        rises.push_back(i);
        if (i > 0) check("burst_pend_at_rise", pending, rises.size() == 2 ? 1 : 0);
      end
      if (done_pulse) dones++;
      if (i == 2) check("burst_pend2", pending, 2);
    end
    check("burst_rises", rises.size(), 3);
    if (rises.size() == 3) begin
      check("burst_gap1", rises[1] - rises[0], 7);
      check("burst_gap2", rises[2] - rises[1], 7);
    end
    check("burst_dones", dones, 3);

    // overflow with ack held low
    do_reset(1, 0, 0);
    pulse_in = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin pulse_in = 1'b1; tick(); end
    check("ovf_full", pending, MAXP);
    check("ovf_none", ovf_sticky, 0);
    pulse_in = 1'b1; tick();
    check("ovf_pulse", ovf_pulse, 1);
    check("ovf_hold", pending, MAXP);
    check("ovf_sticky", ovf_sticky, 1);
    tick();
    check("ovf_pulse_end", ovf_pulse, 0);
    clr_ovf = 1'b1; tick();
    check("ovf_clr", ovf_sticky, 0);
    pulse_in = 1'b1; clr_ovf = 1'b1; tick();
    check("ovf_set_wins", ovf_sticky, 1);

    // slow destination, 40-cycle ack delay, pulses during REQ and REL
    do_reset(0, 0, 40);
    dones = 0; run = 0;
    for (int i = 0; i < 400; i++) begin
      pulse_in = (i == 0 || i == 5 || i == 50);
      prev = req;
      tick();
      if (req) run++;
      if (prev && !req) begin
        check("slow_req_len", run, 40 + SS + 1);
        run = 0;
      end
      if (done_pulse) dones++;
    end
    check("slow_dones", dones, 3);
    check("slow_lost", ovf_sticky, 0);
    check("slow_pending", pending, 0);

    // reset in the middle of REQ with two events queued
    do_reset(1, 0, 0);
    for (int i = 0; i < 3; i++) begin pulse_in = 1'b1; tick(); end
    check("mid_pending", pending, 2);
    check("mid_req", req, 1);
    do_reset(0, 0, 0);
    pulse_in = 1'b1; tick();
    check("post_rst_req", req, 1);
    seen = -1;
    for (int i = 1; i < 10; i++) begin
      tick();
      if (done_pulse && seen < 0) seen = i;
    end
    check("post_rst_done_edge", seen, 6);

    // ack stuck high after reset
    do_reset(1, 1, 0);
    tick(); tick(); tick();
    pulse_in = 1'b1; tick();
    check("stuck_req", req, 0);
    check("stuck_pending", pending, 1);
    tick(); tick();
    ack_force = 1'b0; ack_async = 1'b0;
    seen = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (req && seen < 0) seen = i;
    end
    check("stuck_release_edges", seen, SS + 1);

    // randomized traffic
    for (int s = 0; s < 10; s++) begin
      do_reset(0, 0, $urandom_range(0, 6));
      for (int i = 0; i < 300; i++) begin
        pulse_in = ($urandom_range(0, 3) == 0);
        clr_ovf  = ($urandom_range(0, 15) == 0);
        tick();
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
